ysyx_22041461_mem_responder: RTL



---
 rtl/ysyx_22041461_mem_responder_if.sv | 24 ++
 rtl/ysyx_22041461_mem_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the memory responder (slave).
// One aligned 64-bit access is in flight at a time, with a valid/ready handshake on each half.
interface ysyx_22041461_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22041461_mem_responder.sv
// Synthesizable memory responder: byte-masked 64-bit word store, one access at a time, fixed response latency.
// Define YSYX_22041461_MEM_RESP_ERR_EN to flag out-of-window accesses with resp_err instead of aliasing them.
module ysyx_22041461_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ysyx_22041461_mem_responder_if.slave    bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               valid_q;
    logic [63:0]        rdata_q;

    logic [63:0]        mem [DEPTH];

    logic [63:0]        offset;
    logic [IDX_W-1:0]   idx;
    logic               in_range;
    logic               fire;
    logic               wr_en;

    // The subtraction wraps for addresses below the base, which lands them out of the window.
    assign offset = bus.req_addr - BASE_ADDR;
    assign idx    = IDX_W'(offset >> 3);

`ifdef YSYX_22041461_MEM_RESP_ERR_EN
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;
    logic err_q;

    assign in_range     = (offset < SPAN);
    assign bus.resp_err = err_q;
`else
    assign in_range     = 1'b1;
    assign bus.resp_err = 1'b0;
`endif

    assign fire  = bus.req_valid && ready_q;
    assign wr_en = fire && bus.req_wen && in_range;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;

    // NOTE: the storage array is deliberately left out of reset; a reset would turn it into
    // thousands of flops instead of a RAM, and software never relies on its power-up contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.req_wmask[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: every register here uses <= so all updates see the pre-edge values of each other,
    // which is what makes the single-block FSM order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 64'h0;
`ifdef YSYX_22041461_MEM_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (fire) begin
                        // LATENCY==1 still passes one WAIT cycle with cnt=0 so the response
                        // register rises exactly LATENCY edges after the fire edge.
                        state   <= S_WAIT;
                        cnt     <= CNT_INIT;
                        ready_q <= 1'b0;
                        rdata_q <= (bus.req_wen || !in_range) ? 64'h0 : mem[idx];
`ifdef YSYX_22041461_MEM_RESP_ERR_EN
                        err_q   <= !in_range;
`endif
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state   <= S_RESP;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        rdata_q <= 64'h0;
`ifdef YSYX_22041461_MEM_RESP_ERR_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
